// File: rtl/sys_timer.sv
// Memory-mapped system timer: CTRL/PRESET/COUNT registers, a four-state
// countdown FSM and a maskable interrupt with one-shot and auto-reload modes.
module sys_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_t      state_r;
  logic [3:0]  ctrl_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        flag_r;
  logic        irq_r;

  logic        en_s;
  logic [1:0]  mode_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        enter_int_s;
  logic [3:0]  ctrl_nxt_s;
  logic        flag_nxt_s;

  assign en_s        = ctrl_r[0];
  assign mode_s      = ctrl_r[2:1];
  assign wr_ctrl_s   = we && (addr == ADDR_CTRL);
  assign wr_preset_s = we && (addr == ADDR_PRESET);
  assign enter_int_s = (state_r == CNT) && en_s && (count_r == 32'd0);

  // Next CTRL value: a CPU write beats the hardware EN clear in INT
  always_comb begin
    ctrl_nxt_s = ctrl_r;
    if (wr_ctrl_s) begin
      ctrl_nxt_s = din[3:0];
    end else if ((state_r == INT) && (mode_s != MODE_RELOAD)) begin
      ctrl_nxt_s = {ctrl_r[3:1], 1'b0};
    end else begin
      ctrl_nxt_s = ctrl_r;
    end
  end

  // Next interrupt flag: set on INT entry, cleared by software or by reload
  always_comb begin
    flag_nxt_s = flag_r;
    if (enter_int_s) begin
      flag_nxt_s = 1'b1;
    end else if (wr_ctrl_s || wr_preset_s) begin
      flag_nxt_s = 1'b0;
    end else if ((state_r == INT) && (mode_s == MODE_RELOAD)) begin
      flag_nxt_s = 1'b0;
    end else begin
      flag_nxt_s = flag_r;
    end
  end

  // Register file, countdown FSM and registered interrupt output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ctrl_r   <= 4'd0;
      preset_r <= 32'd0;
      count_r  <= 32'd0;
      flag_r   <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      ctrl_r <= ctrl_nxt_s;
      flag_r <= flag_nxt_s;
      irq_r  <= flag_nxt_s & ctrl_nxt_s[3];
      if (wr_preset_s) begin
        preset_r <= din;
      end else begin
        preset_r <= preset_r;
      end
      case (state_r)
        IDLE: begin
          if (en_s) begin
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          count_r <= preset_r;
          state_r <= CNT;
        end
        CNT: begin
          if (!en_s) begin
            state_r <= IDLE;
          end else if (count_r != 32'd0) begin
            count_r <= count_r - 32'd1;
          end else begin
            state_r <= INT;
          end
        end
        INT: begin
          if (mode_s == MODE_RELOAD) begin
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Combinational read mux; unused upper CTRL bits and addr 3 read as zero
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_CTRL:   dout = {28'd0, ctrl_r};
      ADDR_PRESET: dout = preset_r;
      ADDR_COUNT:  dout = count_r;
      default:     dout = 32'd0;
    endcase
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_sys_timer.sv
// Directed bench for sys_timer: register access, one-shot, auto-reload,
// masking, mid-count PRESET writes, EN clear, reset and write/clear races.
module tb_sys_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_checks;
  int n_fail;

  sys_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_val(tag, dout, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    we       = 1'b0;
    addr     = 2'd0;
    din      = 32'd0;

    // Reset state
    do_reset();
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_preset", 2'd1, 32'd0);
    rd("rst_count", 2'd2, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);

    // One-shot, PRESET=5, CTRL=0x9 written at edge 0
    wr(2'd1, 32'd5);
    rd("os_preset", 2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(2);
    rd("os_cnt_e2", 2'd2, 32'd5);
    step(5);
    rd("os_cnt_e7", 2'd2, 32'd0);
    check_val("os_irq_e7", {31'd0, irq}, 32'd0);
    step(1);
    check_val("os_irq_e8", {31'd0, irq}, 32'd1);
    step(1);
    rd("os_ctrl_e9", 2'd0, 32'h8);
    step(4);
    check_val("os_irq_hold", {31'd0, irq}, 32'd1);
    rd("os_cnt_hold", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    check_val("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=2, CTRL=0xB: INT after edges 5,10,15; COUNT=2 after 2,7,12
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 16; e++) begin
      step(1);
      check_val($sformatf("ar_irq_e%0d", e), {31'd0, irq},
                ((e % 5 == 0) ? 32'd1 : 32'd0));
      if (e % 5 == 2) begin
        rd($sformatf("ar_cnt_e%0d", e), 2'd2, 32'd2);
      end
    end
    rd("ar_ctrl_en", 2'd0, 32'hB);

    // Masked interrupt: IM=0 keeps irq low, then CTRL=0x8 clears the flag
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    step(6);
    check_val("msk_irq_e6", {31'd0, irq}, 32'd0);
    step(1);
    rd("msk_ctrl_e7", 2'd0, 32'h0);
    check_val("msk_irq_e7", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h8);
    check_val("msk_irq_clr", {31'd0, irq}, 32'd0);
    step(2);
    check_val("msk_irq_after", {31'd0, irq}, 32'd0);

    // PRESET rewritten mid-count applies only at the next LOAD
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'hB);
    step(6);
    rd("mid_cnt_e6", 2'd2, 32'd6);
    wr(2'd1, 32'd100);
    rd("mid_cnt_e7", 2'd2, 32'd5);
    step(5);
    rd("mid_cnt_e12", 2'd2, 32'd0);
    step(1);
    check_val("mid_irq_e13", {31'd0, irq}, 32'd1);
    step(2);
    rd("mid_cnt_e15", 2'd2, 32'd100);
    rd("mid_preset", 2'd1, 32'd100);

    // Reset mid-count, then a normal restart with PRESET=1
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(4);
    rd("rmc_cnt_e4", 2'd2, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd("rmc_ctrl", 2'd0, 32'd0);
    rd("rmc_preset", 2'd1, 32'd0);
    rd("rmc_count", 2'd2, 32'd0);
    check_val("rmc_irq", {31'd0, irq}, 32'd0);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step(2);
    rd("rmc_restart_cnt", 2'd2, 32'd1);
    step(2);
    check_val("rmc_restart_irq", {31'd0, irq}, 32'd1);

    // CTRL write while in INT wins over the hardware EN clear
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step(4);
    check_val("race_irq_e4", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h9);
    rd("race_ctrl", 2'd0, 32'h9);
    check_val("race_irq_clr", {31'd0, irq}, 32'd0);
    step(2);
    rd("race_cnt_reload", 2'd2, 32'd1);
    step(2);
    check_val("race_irq_again", {31'd0, irq}, 32'd1);

    // EN cleared mid-count freezes COUNT; COUNT and addr 3 ignore writes
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    step(3);
    rd("frz_cnt_e3", 2'd2, 32'd3);
    wr(2'd0, 32'h0);
    step(2);
    rd("frz_cnt_hold", 2'd2, 32'd2);
    wr(2'd2, 32'h55);
    rd("frz_cnt_ro", 2'd2, 32'd2);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("addr3_zero", 2'd3, 32'd0);
    wr(2'd0, 32'hFFFF_FFF0);
    rd("ctrl_upper_zero", 2'd0, 32'h0);
    wr(2'd0, 32'h1);
    step(2);
    rd("frz_reload", 2'd2, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
